// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle execute-stage ALU: op codes, FSM states, op classification.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package alu_pkg;

    // ALU controller operation codes
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_SLT = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // Shifts take the serial path; everything else resolves in one cycle.
    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational single-cycle ALU ops (AND/OR/ADD/SUB/EQ/SLT); unknown and shift codes give 0.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the owner registers the result.
// Ports: op (4-bit code), a/b (operands), result (DATA_WIDTH).
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = a + b;   // wraps modulo 2^DATA_WIDTH
            OP_SUB:  result = a - b;
            OP_EQ:   result = {{(DATA_WIDTH-1){1'b0}}, (a == b)};
            OP_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, serial one-bit-per-cycle shifts.
// Latency: 1 cycle for single-cycle ops and zero shifts; shamt+1 cycles for shifts.
// Backpressure: valid/ready both sides; result held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk/reset (sync, active-high); in_valid/in_ready + Operation/SrcA/SrcB in;
//        out_valid/out_ready + Result/Zero out (registered).
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Result,
    output logic                  Zero
);

    alu_state_e            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [SHAMT_W-1:0]    cnt;
    logic [3:0]            sh_op;

    logic [DATA_WIDTH-1:0] core_res;
    logic [DATA_WIDTH-1:0] single_res;
    logic [DATA_WIDTH-1:0] sh_next;
    logic [SHAMT_W-1:0]    shamt;
    logic                  accept;

    alu_comb_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .op     (Operation),
        .a      (SrcA),
        .b      (SrcB),
        .result (core_res)
    );

    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid & in_ready;
    assign shamt    = SrcB[SHAMT_W-1:0];

    // A zero-distance shift is just a pass-through of SrcA.
    assign single_res = is_shift(Operation) ? SrcA : core_res;

    // One-bit shift step using the op latched at accept.
    always_comb begin
        sh_next = '0;
        case (sh_op)
            OP_SLL:  sh_next = {shreg[DATA_WIDTH-2:0], 1'b0};
            OP_SRA:  sh_next = {shreg[DATA_WIDTH-1], shreg[DATA_WIDTH-1:1]};
            default: sh_next = {1'b0, shreg[DATA_WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b1;
            cnt       <= '0;
            shreg     <= '0;
            sh_op     <= OP_AND;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_shift(Operation) && (shamt != '0)) begin
                            shreg <= SrcA;
                            cnt   <= shamt;
                            sh_op <= Operation;
                            state <= ST_SHIFT;
                        end else begin
                            Result    <= single_res;
                            Zero      <= (single_res == '0);
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    shreg <= sh_next;
                    cnt   <= cnt - SHAMT_W'(1);
                    // Last step: publish the shifted value directly rather than
                    // waiting a cycle for shreg to settle.
                    if (cnt == SHAMT_W'(1)) begin
                        Result    <= sh_next;
                        Zero      <= (sh_next == '0);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
